mem_req_arbiter: RTL

- Memory-side responder for the per-core cache request interface.
- Accepts instruction fetches, data reads and data writes from CPUS cores, grants one request at a time, and drives the single-ported RAM interface.
- Returns wait/load to the requesting core.
- Sits between the per-core cache blocks and the RAM model, one instance per system.

---
 rtl/mem_req_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: memory-side responder for the per-core cache request
// interface. Grants one instruction fetch, data read or data write at a time
// (data before instruction, round-robin between cores within a class) and
// drives the single-ported RAM. Each access takes an IDLE grant cycle plus
// one or more ACCESS cycles; the granted core sees its wait bit low for the
// single cycle in which the RAM reports ACCESS.
module mem_req_arbiter #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] iload,
  output logic [CPUS*WORD_W-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  localparam int PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {GT_IREAD, GT_DREAD, GT_DWRITE} gtype_t;

  state_t           state, state_nxt;
  gtype_t           gtype, gtype_nxt;
  logic [PTR_W-1:0] gcore, gcore_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;

  logic             sel_found;
  logic [PTR_W-1:0] sel_core;
  gtype_t           sel_type;
  logic [PTR_W-1:0] idx;
  logic             req_live;

  logic [WORD_W-1:0] iaddr_a  [CPUS];
  logic [WORD_W-1:0] daddr_a  [CPUS];
  logic [WORD_W-1:0] dstore_a [CPUS];

  // Unpack the per-core buses so the granted core can be selected by index.
  for (genvar c = 0; c < CPUS; c++) begin : g_unpack
    assign iaddr_a[c]  = iaddr[c*WORD_W +: WORD_W];
    assign daddr_a[c]  = daddr[c*WORD_W +: WORD_W];
    assign dstore_a[c] = dstore[c*WORD_W +: WORD_W];
  end

  // Read data is broadcast; a core only trusts it while its wait bit is low.
  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

  // Grant selection: scan cores from the round-robin pointer, data class first.
  always_comb begin
    sel_found = 1'b0;
    sel_core  = '0;
    sel_type  = GT_IREAD;
    idx       = '0;
    for (int k = 0; k < CPUS; k++) begin
      idx = (CPUS == 1) ? '0 : ptr + PTR_W'(k);
      if (!sel_found && (dREN[idx] || dWEN[idx])) begin
        sel_found = 1'b1;
        sel_core  = idx;
        sel_type  = dWEN[idx] ? GT_DWRITE : GT_DREAD;
      end
    end
    for (int k = 0; k < CPUS; k++) begin
      idx = (CPUS == 1) ? '0 : ptr + PTR_W'(k);
      if (!sel_found && iREN[idx]) begin
        sel_found = 1'b1;
        sel_core  = idx;
        sel_type  = GT_IREAD;
      end
    end
  end

  // Next state, RAM drive, completion/abort handling and pointer update.
  always_comb begin
    state_nxt = state;
    gtype_nxt = gtype;
    gcore_nxt = gcore;
    ptr_nxt   = ptr;
    iwait     = '1;
    dwait     = '1;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    req_live  = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          gcore_nxt = sel_core;
          gtype_nxt = sel_type;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        case (gtype)
          GT_DWRITE: req_live = dWEN[gcore];
          GT_DREAD:  req_live = dREN[gcore];
          default:   req_live = iREN[gcore];
        endcase
        if (!req_live) begin
          // Requester withdrew: drop the RAM access, no completion.
          state_nxt = IDLE;
        end else begin
          ramaddr  = (gtype == GT_IREAD) ? iaddr_a[gcore] : daddr_a[gcore];
          ramstore = dstore_a[gcore];
          ramWEN   = (gtype == GT_DWRITE);
          ramREN   = (gtype != GT_DWRITE);
          if (ramstate == RAM_ACCESS) begin
            state_nxt = IDLE;
            ptr_nxt   = (CPUS == 1) ? '0 : gcore + PTR_W'(1);
            if (gtype == GT_IREAD) iwait[gcore] = 1'b0;
            else                   dwait[gcore] = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      gtype <= GT_IREAD;
      gcore <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gtype <= gtype_nxt;
      gcore <= gcore_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule
